instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader_pkg.sv | 14 +
 rtl/instr_mem_loader_if.sv | 29 ++
 rtl/instr_mem_loader_byte_assembler.sv | 31 +++
 rtl/instr_mem_loader.sv | 78 +++++++
 tb/tb_instr_mem_loader.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/instr_mem_loader_pkg.sv
// instr_mem_loader_pkg: shared processor widths, depths and loader state encoding
package instr_mem_loader_pkg;
  localparam int DEF_INSTR_WIDTH = 32;
  localparam int DEF_ADDRESS_WIDTH = 32;
  localparam int DEF_MEM_DEPTH = 100;
  localparam int DEF_LEN_W = $clog2(DEF_MEM_DEPTH + 1);
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE,
    ERROR
  } state_t;
endpackage

// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: load request, serial byte stream and memory write port of the loader
interface instr_mem_loader_if
  import instr_mem_loader_pkg::*;
#(
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
);
  localparam int LEN_W = $clog2(MEM_DEPTH + 1);
  logic start;
  logic [LEN_W-1:0] load_length;
  logic [7:0] in_byte;
  logic in_valid;
  logic out_ready;
  logic wr_en;
  logic [ADDRESS_WIDTH-1:0] wr_address;
  logic [INSTR_WIDTH-1:0] wr_data;
  logic cpu_hold;
  logic load_done;
  logic load_error;
  modport master (
    output start, load_length, in_byte, in_valid,
    input out_ready, wr_en, wr_address, wr_data, cpu_hold, load_done, load_error
  );
  modport slave (
    input start, load_length, in_byte, in_valid,
    output out_ready, wr_en, wr_address, wr_data, cpu_hold, load_done, load_error
  );
endinterface

// File: rtl/instr_mem_loader_byte_assembler.sv
// instr_mem_loader_byte_assembler: places accepted bytes little-endian into a 32-bit word
module instr_mem_loader_byte_assembler (
  input logic clk,
  input logic rst_n,
  input logic clear,
  input logic accept,
  input logic [7:0] in_byte,
  output logic [31:0] word,
  output logic word_done
);
  logic [1:0] cnt_q;
  logic [31:0] word_q;
  // word as it will look once the current byte lands in its lane
  always_comb begin
    for (int i = 0; i < 4; i++) word[8*i +: 8] = (cnt_q == 2'(i)) ? in_byte : word_q[8*i +: 8];
    word_done = accept && cnt_q == 2'd3;
  end
  // byte lane counter wraps 3->0; partial bytes survive stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      word_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
      word_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + 2'd1;
      word_q <= word;
    end
  end
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: streams serial bytes into instruction memory words while holding the CPU
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
  input logic clk,
  input logic rst_n,
  instr_mem_loader_if.slave bus
);
  localparam int LEN_W = $clog2(MEM_DEPTH + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MEM_DEPTH);
  state_t state_q, state_d;
  logic [LEN_W-1:0] len_q, word_idx_q, word_idx_inc;
  logic [INSTR_WIDTH-1:0] wr_data_q;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q;
  logic [31:0] word;
  logic can_start, len_ok, start_ok, start_bad, accept, word_done;
  assign can_start = state_q inside {IDLE, DONE, ERROR};
  assign len_ok = bus.load_length != '0 && bus.load_length <= MAX_LEN;
  assign start_ok = bus.start && can_start && len_ok;
  assign start_bad = bus.start && can_start && !len_ok;
  assign accept = bus.in_valid && state_q == LOAD;
  assign word_idx_inc = word_idx_q + LEN_W'(1);
  instr_mem_loader_byte_assembler u_asm (
    .clk(clk),
    .rst_n(rst_n),
    .clear(start_ok),
    .accept(accept),
    .in_byte(bus.in_byte),
    .word(word),
    .word_done(word_done)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next state and state-decoded outputs
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERROR: state_d = start_ok ? LOAD : start_bad ? ERROR : state_q;
      LOAD: state_d = word_done ? WRITE : LOAD;
      WRITE: state_d = (word_idx_inc == len_q) ? DONE : LOAD;
      default: state_d = IDLE;
    endcase
    bus.out_ready = state_q == LOAD;
    bus.wr_en = state_q == WRITE;
    bus.cpu_hold = state_q != DONE;
    bus.load_done = state_q == DONE;
    bus.load_error = state_q == ERROR;
    bus.wr_address = wr_addr_q;
    bus.wr_data = wr_data_q;
  end
  // load length, word index and the write-port registers captured on word completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
      word_idx_q <= '0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
    end else begin
      if (start_ok) begin
        len_q <= bus.load_length;
        word_idx_q <= '0;
      end else if (state_q == WRITE) begin
        word_idx_q <= word_idx_inc;
      end
      if (word_done) begin
        wr_data_q <= INSTR_WIDTH'(word);
        wr_addr_q <= ADDRESS_WIDTH'({word_idx_q, 2'b00});
      end
    end
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed and randomized loads checked against a byte-stream model
module tb_instr_mem_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int passed = 0;
  int total = 0;
  logic [7:0] prog[$];
  logic [63:0] obs_q[$];
  instr_mem_loader_if bus ();
  instr_mem_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // capture every memory write strobe away from the clock edge
  always @(negedge clk) if (bus.wr_en === 1'b1) obs_q.push_back({bus.wr_address, bus.wr_data});
  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endfunction
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_start(input logic [6:0] len);
    bus.start = 1'b1;
    bus.load_length = len;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] v);
    bit ok = 0;
    bus.in_byte = v;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = bus.out_ready === 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("byte_accept", 32'(ok), 32'd1);
  endtask
  task automatic fill_random(input int n);
    prog.delete();
    repeat (n) prog.push_back(8'($urandom));
  endtask
  function automatic logic [31:0] model_word(input int w);
    return 32'(prog[4*w]) + (32'(prog[4*w+1]) << 8) + (32'(prog[4*w+2]) << 16) + (32'(prog[4*w+3]) << 24);
  endfunction
  task automatic run_load(input int len, input int gap, input bit noise);
    obs_q.delete();
    do_start(7'(len));
    chk("start_ready", 32'(bus.out_ready), 32'd1);
    chk("start_hold", 32'(bus.cpu_hold), 32'd1);
    chk("start_done", 32'(bus.load_done), 32'd0);
    chk("start_err", 32'(bus.load_error), 32'd0);
    for (int i = 0; i < len * 4; i++) begin
      send_byte(prog[i]);
      if (i % 4 == 3) begin
        chk("lat_wren", 32'(bus.wr_en), 32'd1);
        chk("lat_ready", 32'(bus.out_ready), 32'd0);
      end else if (gap > 0) idle(gap);
      if (noise && i == 10) begin
        do_start(7'd3);
        chk("noise_ready", 32'(bus.out_ready), 32'd1);
      end
    end
    for (int t = 0; t < 10 && bus.load_done !== 1'b1; t++) idle(1);
    chk("done", 32'(bus.load_done), 32'd1);
    chk("done_hold", 32'(bus.cpu_hold), 32'd0);
    chk("wr_count", 32'(obs_q.size()), 32'(len));
    for (int w = 0; w < len && w < obs_q.size(); w++) begin
      chk("wr_addr", obs_q[w][63:32], 32'(4 * w));
      chk("wr_data", obs_q[w][31:0], model_word(w));
    end
    chk("hold_addr", bus.wr_address, 32'(4 * (len - 1)));
    chk("hold_data", bus.wr_data, model_word(len - 1));
  endtask
  initial begin
    bus.start = 1'b0;
    bus.load_length = '0;
    bus.in_byte = '0;
    bus.in_valid = 1'b0;
    #12;
    chk("rst_ready", 32'(bus.out_ready), 32'd0);
    chk("rst_wren", 32'(bus.wr_en), 32'd0);
    chk("rst_hold", 32'(bus.cpu_hold), 32'd1);
    chk("rst_done", 32'(bus.load_done), 32'd0);
    chk("rst_err", 32'(bus.load_error), 32'd0);
    chk("rst_addr", bus.wr_address, 32'd0);
    chk("rst_data", bus.wr_data, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    prog = '{8'h13, 8'h00, 8'h08, 8'h20, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(2, 0, 0);
    chk("ex_w0", obs_q.size() > 0 ? obs_q[0][31:0] : 32'hx, 32'h20080013);
    chk("ex_w1", obs_q.size() > 1 ? obs_q[1][31:0] : 32'hx, 32'h00100093);
    prog = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(1, 5, 0);
    chk("gap_w0", obs_q.size() > 0 ? obs_q[0][31:0] : 32'hx, 32'h44332211);
    idle(5);
    chk("gap_no_extra", 32'(obs_q.size()), 32'd1);
    obs_q.delete();
    do_start(7'd0);
    chk("err0", 32'(bus.load_error), 32'd1);
    chk("err0_ready", 32'(bus.out_ready), 32'd0);
    chk("err0_hold", 32'(bus.cpu_hold), 32'd1);
    do_start(7'd101);
    chk("err101", 32'(bus.load_error), 32'd1);
    chk("err101_ready", 32'(bus.out_ready), 32'd0);
    idle(3);
    chk("err_no_wr", 32'(obs_q.size()), 32'd0);
    fill_random(4);
    run_load(1, 0, 0);
    fill_random(12);
    obs_q.delete();
    do_start(7'd3);
    send_byte(prog[0]);
    send_byte(prog[1]);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(bus.out_ready), 32'd0);
    chk("arst_hold", 32'(bus.cpu_hold), 32'd1);
    chk("arst_data", bus.wr_data, 32'd0);
    chk("arst_addr", bus.wr_address, 32'd0);
    chk("arst_done", 32'(bus.load_done), 32'd0);
    chk("arst_err", 32'(bus.load_error), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    fill_random(12);
    run_load(3, 1, 0);
    repeat (3) begin
      int len = $urandom_range(1, 6);
      fill_random(len * 4);
      run_load(len, $urandom_range(0, 3), 0);
    end
    fill_random(400);
    run_load(100, 0, 1);
    chk("full_last_addr", obs_q.size() == 100 ? obs_q[99][63:32] : 32'hx, 32'h18c);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
